// File: rtl/fc_output_frame_assembler_if.sv
// ---------------------------------------------------------------------------
// fc_output_frame_assembler_if
//   Bundles the serial word stream from the FC network and the parallel frame
//   stream towards the localization result sink.
//
//   Parameters:
//     DATA_WIDTH  - width of each signed word
//     NUM_OUTPUTS - words per frame
//     ID_WIDTH    - frame sequence number width
//
//   Signals:
//     in_data / in_valid / in_ready          - serial input stream
//                                               (word returned one cycle
//                                               after ready)
//     frame_data / frame_valid / frame_ready - assembled frame handshake
//     frame_id                               - sequence number of the frame
//     partial                                - assembly buffer non-empty
//     overflow                               - sticky dropped-word flag
//
//   Modports:
//     master - environment side (upstream source plus frame sink)
//     slave  - the assembler
// ---------------------------------------------------------------------------
interface fc_output_frame_assembler_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_OUTPUTS = 3,
  parameter int ID_WIDTH    = 8
);
  logic signed [DATA_WIDTH-1:0]             in_data;
  logic                                     in_valid;
  logic                                     in_ready;
  logic        [NUM_OUTPUTS*DATA_WIDTH-1:0] frame_data;
  logic                                     frame_valid;
  logic                                     frame_ready;
  logic        [ID_WIDTH-1:0]               frame_id;
  logic                                     partial;
  logic                                     overflow;

  modport master (
    output in_data, in_valid, frame_ready,
    input  in_ready, frame_data, frame_valid, frame_id, partial, overflow
  );

  modport slave (
    input  in_data, in_valid, frame_ready,
    output in_ready, frame_data, frame_valid, frame_id, partial, overflow
  );
endinterface

// File: rtl/fc_output_frame_assembler.sv
// ---------------------------------------------------------------------------
// fc_output_frame_assembler
//   Collects NUM_OUTPUTS consecutive signed words from the FC output stream
//   into one parallel frame and presents it, tagged with a sequence number,
//   on a valid/ready interface. An assembly buffer plus an output register
//   form a ping-pong pair so collection continues while the sink stalls.
//
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset
//     flush - synchronous clear of buffered data (id counter kept)
//     bus   - slave side of fc_output_frame_assembler_if (stream in,
//             frame out, partial/overflow status)
// ---------------------------------------------------------------------------
module fc_output_frame_assembler #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_OUTPUTS = 3,
  parameter int ID_WIDTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  fc_output_frame_assembler_if.slave   bus
);

  localparam int CNT_W   = $clog2(NUM_OUTPUTS + 1);
  localparam int OCC_W   = $clog2(2 * NUM_OUTPUTS + 1);
  localparam int FRAME_W = NUM_OUTPUTS * DATA_WIDTH;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_OUTPUTS);
  localparam logic [OCC_W-1:0] FRAME_OCC = OCC_W'(NUM_OUTPUTS);
  // Ready is held while at least two slots are free: one for the word that
  // may already be in flight and one for the word this ready requests.
  localparam logic [OCC_W-1:0] READY_MAX = OCC_W'(2 * NUM_OUTPUTS - 2);

  logic [CNT_W-1:0]      r_asm_cnt;
  logic [DATA_WIDTH-1:0] r_asm_buf [NUM_OUTPUTS];
  logic [FRAME_W-1:0]    r_frame_data;
  logic                  r_frame_valid;
  logic [ID_WIDTH-1:0]   r_frame_id;
  logic [ID_WIDTH-1:0]   r_id_ctr;
  logic                  r_overflow;

  logic [FRAME_W-1:0]    w_asm_packed;
  logic [OCC_W-1:0]      w_occ;
  logic                  w_slot_free;
  logic                  w_transfer;
  logic                  w_store;
  logic [CNT_W-1:0]      w_wr_slot;

  // Word k of the frame sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
  generate
    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_pack
      assign w_asm_packed[gi*DATA_WIDTH +: DATA_WIDTH] = r_asm_buf[gi];
    end
  endgenerate

  assign w_occ       = OCC_W'(r_asm_cnt) + (r_frame_valid ? FRAME_OCC : '0);
  assign w_slot_free = (r_asm_cnt != FULL_CNT);
  assign w_transfer  = (r_asm_cnt == FULL_CNT) && (!r_frame_valid || bus.frame_ready);
  // In a transfer cycle the buffer empties, so an arriving word goes to slot 0.
  assign w_store     = bus.in_valid && !flush && (w_slot_free || w_transfer);
  assign w_wr_slot   = w_transfer ? '0 : r_asm_cnt;

  // Data-only storage; contents are meaningless until asm_cnt covers them,
  // so no reset is needed here.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      if (w_store && (w_wr_slot == CNT_W'(k))) begin
        r_asm_buf[k] <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm_cnt     <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_id    <= '0;
      r_id_ctr      <= '0;
      r_overflow    <= 1'b0;
    end else if (flush) begin
      r_asm_cnt     <= '0;
      r_frame_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_transfer) begin
        r_frame_data  <= w_asm_packed;
        r_frame_valid <= 1'b1;
        r_frame_id    <= r_id_ctr;
        r_id_ctr      <= r_id_ctr + 1'b1;
      end else if (r_frame_valid && bus.frame_ready) begin
        r_frame_valid <= 1'b0;
      end

      if (w_transfer) begin
        r_asm_cnt <= bus.in_valid ? CNT_W'(1) : '0;
      end else if (bus.in_valid && w_slot_free) begin
        r_asm_cnt <= r_asm_cnt + 1'b1;
      end

      // Only an upstream that ignores in_ready can reach this.
      if (bus.in_valid && !w_slot_free && !w_transfer) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = (w_occ <= READY_MAX);
  assign bus.frame_data  = r_frame_data;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_id    = r_frame_id;
  assign bus.partial     = (r_asm_cnt != '0);
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_fc_output_frame_assembler.sv
module tb_fc_output_frame_assembler;

  localparam int DW = 16;
  localparam int N  = 3;
  localparam int IW = 8;
  localparam int FW = N * DW;

  typedef struct {
    logic [FW-1:0] data;
    logic [IW-1:0] id;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic ready_q = 1'b0;

  always #5 clk = ~clk;

  fc_output_frame_assembler_if #(.DATA_WIDTH(DW), .NUM_OUTPUTS(N), .ID_WIDTH(IW)) bus ();

  fc_output_frame_assembler #(.DATA_WIDTH(DW), .NUM_OUTPUTS(N), .ID_WIDTH(IW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] part_q[$];
  logic [DW-1:0] fixed_q[$];
  exp_t          sb[$];
  logic [IW-1:0] model_id = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: every N stored words make one frame with the next model id.
  function automatic void model_store(input logic [DW-1:0] w);
    exp_t e;
    part_q.push_back(w);
    if (part_q.size() == N) begin
      e.data = '0;
      for (int k = 0; k < N; k++) e.data[k*DW +: DW] = part_q[k];
      e.id = model_id;
      model_id = model_id + 1'b1;
      sb.push_back(e);
      part_q.delete();
    end
  endfunction

  // Upstream request seen by the source: in_ready of the previous cycle.
  always @(posedge clk) ready_q <= bus.in_ready;

  // Sink-side monitor: pops the scoreboard on each accepted frame and checks
  // that a stalled frame holds still.
  logic [FW-1:0] prev_data;
  logic [IW-1:0] prev_id;
  logic          prev_hold = 1'b0;

  always @(negedge clk) begin
    if (prev_hold && bus.frame_valid) begin
      check_eq("hold_data", 64'(bus.frame_data), 64'(prev_data));
      check_eq("hold_id", 64'(bus.frame_id), 64'(prev_id));
    end
    prev_hold <= rst_n && bus.frame_valid && !bus.frame_ready;
    prev_data <= bus.frame_data;
    prev_id   <= bus.frame_id;
    if (rst_n && bus.frame_valid && bus.frame_ready) begin
      check_eq("frame_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        $display("frame id=%0d data=%h (exp id=%0d data=%h)",
                 bus.frame_id, bus.frame_data, sb[0].id, sb[0].data);
        check_eq("frame_data", 64'(bus.frame_data), 64'(sb[0].data));
        check_eq("frame_id", 64'(bus.frame_id), 64'(sb[0].id));
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers up to max_words words over 'cycles' cycles. With honour set, a
  // word is sent only if in_ready was high the previous cycle; drop_idx marks
  // the word the DUT is expected to discard.
  task automatic stream(input int max_words, input int cycles, input bit honour,
                        input int drop_idx, output int sent);
    logic [DW-1:0] w;
    sent = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (sent < max_words && (!honour || ready_q)) begin
        if (fixed_q.size() > 0) w = fixed_q.pop_front();
        else w = DW'($urandom);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        if (sent != drop_idx) model_store(w);
        $display("word %0d: %h%s", sent, w, (sent == drop_idx) ? " (expect drop)" : "");
        sent++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  int sent;
  logic [DW-1:0] wsim;

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.frame_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 64'(bus.frame_valid), 64'd0);
    check_eq("rst_data", 64'(bus.frame_data), 64'd0);
    check_eq("rst_id", 64'(bus.frame_id), 64'd0);
    check_eq("rst_partial", 64'(bus.partial), 64'd0);
    check_eq("rst_overflow", 64'(bus.overflow), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    rst_n = 1'b1;

    // Single frame, latency and one-cycle valid
    bus.frame_ready = 1'b1;
    fixed_q = '{16'h0100, 16'hFF00, 16'h0800};
    stream(3, 3, 1'b1, -1, sent);
    check_eq("single_sent", 64'(sent), 64'd3);
    @(negedge clk);
    check_eq("single_valid_e", 64'(bus.frame_valid), 64'd0);
    check_eq("single_partial_e", 64'(bus.partial), 64'd1);
    @(negedge clk);
    check_eq("single_valid_e1", 64'(bus.frame_valid), 64'd1);
    check_eq("single_data", 64'(bus.frame_data), 64'h0000_0800_FF00_0100);
    check_eq("single_id", 64'(bus.frame_id), 64'd0);
    @(negedge clk);
    check_eq("single_pulse", 64'(bus.frame_valid), 64'd0);

    // Backpressure with an upstream honouring the ready latency
    step();
    bus.frame_ready = 1'b0;
    stream(9, 10, 1'b1, -1, sent);
    check_eq("bp_words_held", 64'(sent), 64'd6);
    @(negedge clk);
    check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("bp_overflow", 64'(bus.overflow), 64'd0);
    check_eq("bp_valid", 64'(bus.frame_valid), 64'd1);
    check_eq("bp_partial", 64'(bus.partial), 64'd1);
    step();
    bus.frame_ready = 1'b1;
    stream(3, 8, 1'b1, -1, sent);
    check_eq("bp_rest_sent", 64'(sent), 64'd3);
    idle(8);
    check_eq("bp_drained", 64'(sb.size()), 64'd0);

    // Overflow: upstream ignores in_ready, 7th word dropped
    bus.frame_ready = 1'b0;
    stream(7, 7, 1'b0, 6, sent);
    @(negedge clk);
    check_eq("ovf_set", 64'(bus.overflow), 64'd1);
    check_eq("ovf_in_ready", 64'(bus.in_ready), 64'd0);
    idle(3);
    @(negedge clk);
    check_eq("ovf_sticky", 64'(bus.overflow), 64'd1);
    step();
    bus.frame_ready = 1'b1;
    idle(6);
    @(negedge clk);
    check_eq("ovf_sticky_drained", 64'(bus.overflow), 64'd1);
    check_eq("ovf_drained", 64'(sb.size()), 64'd0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check_eq("ovf_flush_clear", 64'(bus.overflow), 64'd0);

    // Simultaneous transfer, drain and accept
    step();
    bus.frame_ready = 1'b0;
    stream(6, 6, 1'b0, -1, sent);
    @(negedge clk);
    check_eq("sim_a_held", 64'(bus.frame_valid), 64'd1);
    check_eq("sim_full_ready", 64'(bus.in_ready), 64'd0);
    step();
    wsim = DW'($urandom);
    bus.frame_ready = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_data     = wsim;
    model_store(wsim);
    $display("word sim: %h", wsim);
    step();
    bus.in_valid    = 1'b0;
    bus.frame_ready = 1'b0;
    @(negedge clk);
    check_eq("sim_b_valid", 64'(bus.frame_valid), 64'd1);
    check_eq("sim_b_id", 64'(bus.frame_id), 64'(sb.size() != 0 ? sb[0].id : ~model_id));
    check_eq("sim_partial", 64'(bus.partial), 64'd1);
    check_eq("sim_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.frame_ready = 1'b1;
    stream(2, 4, 1'b1, -1, sent);
    idle(6);
    check_eq("sim_drained", 64'(sb.size()), 64'd0);

    // Flush mid-frame; a word in the flush cycle is dropped silently
    stream(2, 2, 1'b1, -1, sent);
    @(negedge clk);
    check_eq("flush_pre_partial", 64'(bus.partial), 64'd1);
    step();
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7FFF;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    part_q.delete();
    @(negedge clk);
    check_eq("flush_partial", 64'(bus.partial), 64'd0);
    check_eq("flush_valid", 64'(bus.frame_valid), 64'd0);
    check_eq("flush_overflow", 64'(bus.overflow), 64'd0);
    stream(3, 3, 1'b1, -1, sent);
    idle(4);
    check_eq("flush_drained", 64'(sb.size()), 64'd0);

    // Reset mid-operation
    stream(2, 2, 1'b1, -1, sent);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", 64'(bus.frame_valid), 64'd0);
    check_eq("mrst_data", 64'(bus.frame_data), 64'd0);
    check_eq("mrst_id", 64'(bus.frame_id), 64'd0);
    check_eq("mrst_partial", 64'(bus.partial), 64'd0);
    check_eq("mrst_overflow", 64'(bus.overflow), 64'd0);
    check_eq("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    part_q.delete();
    sb.delete();
    model_id = '0;
    bus.frame_ready = 1'b1;
    stream(3, 3, 1'b1, -1, sent);
    idle(4);
    check_eq("mrst_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
